// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: next-PC select codes and IR field positions shared by the fetch unit and the controller.
//   PC_SRC_*  : pc_src encodings (hold / jump / increment / branch)
//   *_LSB     : low bit of each 4-bit IR field; IMM_W is the immediate width
package fetch_unit_pkg;
  localparam logic [1:0] PC_SRC_HOLD   = 2'b00;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
  localparam logic [1:0] PC_SRC_INC    = 2'b10;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b11;
  localparam int OP_LSB  = 12;
  localparam int A_LSB   = 8;
  localparam int EXT_LSB = 4;
  localparam int B_LSB   = 0;
  localparam int FIELD_W = 4;
  localparam int IMM_W   = 8;
endpackage

// File: rtl/fetch_unit_pc_next_mux.sv
// pc_next_mux: combinational next-PC select with wrapping adders.
//   pc_i          current PC
//   pc_src_i      select: hold / jump / increment / branch
//   jump_target_i register value for jumps (truncated to ADDR_BITS)
//   disp_i        8-bit branch displacement, sign-extended and added to pc_i
//   pc_next_o     selected next PC
//   pc_plus_one_o pc_i + 1 modulo 2**ADDR_BITS
module pc_next_mux
  import fetch_unit_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 16
) (
  input  logic [ADDR_BITS-1:0] pc_i,
  input  logic [1:0]           pc_src_i,
  input  logic [WIDTH-1:0]     jump_target_i,
  input  logic [IMM_W-1:0]     disp_i,
  output logic [ADDR_BITS-1:0] pc_next_o,
  output logic [ADDR_BITS-1:0] pc_plus_one_o
);
  logic [ADDR_BITS-1:0] disp_ext;
  always_comb begin
    disp_ext      = {{(ADDR_BITS-IMM_W){disp_i[IMM_W-1]}}, disp_i};
    pc_plus_one_o = pc_i + ADDR_BITS'(1);
    pc_next_o     = pc_src_i == PC_SRC_JUMP   ? ADDR_BITS'(jump_target_i) :
                    pc_src_i == PC_SRC_INC    ? pc_plus_one_o :
                    pc_src_i == PC_SRC_BRANCH ? pc_i + disp_ext :
                    pc_i;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, instruction register, IR field decode and retired-instruction counter.
//   clk, reset (sync, active-low)
//   instruction_en/mem_rdata : IR load
//   pc_en/pc_src/jump_target : next-PC control
//   pc, pc_plus_one          : fetch address and link value
//   op_code/A_index/ext_op_code/B_index/imm_sext/imm_zext : IR decode
//   retired                  : count of PC updates
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                 WIDTH     = 16,
  parameter int                 ADDR_BITS = 16,
  parameter logic [ADDR_BITS-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instruction_en,
  input  logic [WIDTH-1:0]     mem_rdata,
  input  logic                 pc_en,
  input  logic [1:0]           pc_src,
  input  logic [WIDTH-1:0]     jump_target,
  output logic [ADDR_BITS-1:0] pc,
  output logic [ADDR_BITS-1:0] pc_plus_one,
  output logic [3:0]           op_code,
  output logic [3:0]           A_index,
  output logic [3:0]           ext_op_code,
  output logic [3:0]           B_index,
  output logic [WIDTH-1:0]     imm_sext,
  output logic [WIDTH-1:0]     imm_zext,
  output logic [15:0]          retired
);
  logic [WIDTH-1:0]     ir_q;
  logic [ADDR_BITS-1:0] pc_q, pc_d;
  logic [15:0]          retired_q;
  pc_next_mux #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) u_mux (
    .pc_i         (pc_q),
    .pc_src_i     (pc_src),
    .jump_target_i(jump_target),
    .disp_i       (ir_q[IMM_W-1:0]),
    .pc_next_o    (pc_d),
    .pc_plus_one_o(pc_plus_one)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      ir_q      <= '0;
      pc_q      <= RESET_PC;
      retired_q <= '0;
    end else begin
      if (instruction_en) ir_q <= mem_rdata;
      if (pc_en) begin
        pc_q      <= pc_d;
        retired_q <= retired_q + 16'd1;
      end
    end
  end
  always_comb begin
    pc          = pc_q;
    retired     = retired_q;
    op_code     = ir_q[OP_LSB +: FIELD_W];
    A_index     = ir_q[A_LSB +: FIELD_W];
    ext_op_code = ir_q[EXT_LSB +: FIELD_W];
    B_index     = ir_q[B_LSB +: FIELD_W];
    imm_sext    = {{(WIDTH-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
    imm_zext    = {{(WIDTH-IMM_W){1'b0}}, ir_q[IMM_W-1:0]};
  end
endmodule
